mm_rr_arbiter: RTL
==================

Name: mm_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Montgomery modular multiplier core among NREQ requesters, such as the exponentiation controller, a point-arithmetic unit and a host port.
- Accepts one operand pair per grant and launches the core with a one-cycle start pulse.
- Waits for a fresh rising completion from the core, then returns the product to the granted requester only.
- Contains a watchdog that ends a hung operation with an error response.

Parameters:
K, 192, operand/result width in bits
NREQ, 4, number of requesters
IDW, 2, width of the requester index (ceil log2 NREQ)
TMO, 1024, watchdog limit in cycles, counted from LAUNCH+1 until mm_done is accepted
TMOW, 16, width of the watchdog counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  reset, synchronous, active-high; shared with the multiplier core
req  in  NREQ  per-requester request level, held until gnt
req_a  in  NREQ*K  operand 1 of requester i at bits [i*K +: K]
req_b  in  NREQ*K  operand 2 of requester i at bits [i*K +: K]
gnt  out  NREQ  one-hot, one-cycle acceptance pulse; operands sampled on that edge
rsp_valid  out  NREQ  one-hot, one-cycle response pulse
rsp_data  out  K  product, valid while any rsp_valid bit is high, else 0
rsp_err  out  1  watchdog error flag, qualified by rsp_valid
mm_op1  out  K  operand 1 to the core, stable from LAUNCH until RESP
mm_op2  out  K  operand 2 to the core, stable from LAUNCH until RESP
mm_start  out  1  one-cycle start pulse to the core
mm_result  in  K  result from the core, sampled when mm_done is accepted
mm_done  in  1  completion level from the core; may already be high before start
busy  out  1  high whenever the state is not IDLE
cur_id  out  IDW  index of the requester being served; 0 in IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, watchdog=0; every output is 0.
- States: IDLE, LAUNCH, ARM, WAIT, RESP.
- IDLE:
  - The winner is the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - gnt[winner]=1 combinationally in the same cycle.
  - On that edge: capture req_a/req_b of the winner into op registers, set cur_id=winner, set rr_ptr=(winner+1) mod NREQ, go to LAUNCH.
  - With no request, stay in IDLE; gnt=0.
- LAUNCH: mm_start=1 for exactly one cycle, then go to ARM.
- ARM:
  - Wait for mm_done=0, which guarantees a stale done from a previous operation is never accepted.
  - On mm_done=0, go to WAIT. If mm_done stays 1, remain in ARM.
- WAIT: on mm_done=1, register mm_result into the response register and go to RESP.
- RESP:
  - rsp_valid[cur_id]=1 and rsp_data=response register for one cycle, then go to IDLE.
  - A new grant is possible in the cycle immediately after RESP.
- Watchdog:
  - Clears in LAUNCH and increments every cycle in ARM or WAIT.
  - When it reaches TMO-1 without mm_done being accepted: response register=0, rsp_err=1, go to RESP.
  - mm_done arriving on that same cycle wins: normal response, rsp_err=0.
- Minimum latency from gnt to rsp_valid: 4 cycles plus the core compute time.
- A request dropped before its gnt is withdrawn with no side effect.
- req and operand changes by a requester after its gnt have no effect on the running operation.
- The granted requester may re-request in the RESP cycle, but is granted only in a later IDLE cycle, behind any pending lower-priority requesters.
- At most one operation is in flight. gnt and rsp_valid are never asserted in the same cycle.
- Reset mid-operation:
  - Immediate return to IDLE with reset values.
  - No rsp_valid for the aborted operation.
  - The in-flight requester must re-request.
- Widths: there is no arithmetic on operands. rr_ptr and cur_id wrap modulo NREQ. The watchdog never wraps because it saturates at TMO-1.

Test Plan:
- Bench core model returns a*b mod 2^K after 10 cycles; done goes low on start and high on completion. Stimulus: reset, then req[2] with a=5, b=7. Required: gnt[2] in the request cycle, mm_start one cycle later, rsp_valid[2] with rsp_data=35 and rsp_err=0, busy low the cycle after.
- Stimulus: all four req high from the cycle after reset, with a=i+1, b=10. Required: grants in order 0,1,2,3; responses 10,20,30,40, each arriving before the next gnt.
- Stimulus: req[0] and req[3] held continuously. Required: grant sequence 0,3,0,3,…; no requester granted twice in a row while the other is pending.
- Stimulus: model holds mm_done=1 for 3 cycles after start before dropping it. Required: FSM stays in ARM; response carries the fresh result and does not occur before the model's real completion.
- Stimulus: TMO=16 and a model that never completes. Required: rsp_valid[cur_id]=1, rsp_err=1, rsp_data=0 exactly 16 cycles after LAUNCH; state returns to IDLE and the next request is served normally.
- Stimulus: reset asserted during WAIT for requester 1, then req[3] and req[0] raised together. Required: all outputs 0 on the reset cycle, no rsp_valid for requester 1, next grant goes to 0 because rr_ptr=0.

Source files
------------

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one Montgomery multiplier core
// among NREQ requesters, with a stale-done guard and a hang watchdog.
module mm_rr_arbiter #(
  parameter int K    = 192,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 1024,
  parameter int TMOW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*K-1:0] req_a,
  input  logic [NREQ*K-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [K-1:0]      rsp_data,
  output logic              rsp_err,
  output logic [K-1:0]      mm_op1,
  output logic [K-1:0]      mm_op2,
  output logic              mm_start,
  input  logic [K-1:0]      mm_result,
  input  logic              mm_done,
  output logic              busy,
  output logic [IDW-1:0]    cur_id,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // Handshake: req[i] is a level held until gnt[i]; gnt[i] is a one-cycle pulse
  // and the operands are sampled on that same rising edge. rsp_valid[i] is a
  // one-cycle pulse with rsp_data/rsp_err valid only while it is high.

  logic [2:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [K-1:0]    op1_q, op1_d;
  logic [K-1:0]    op2_q, op2_d;
  logic [K-1:0]    rsp_q, rsp_d;
  logic            err_q, err_d;
  logic [TMOW-1:0] wd_q, wd_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic [K-1:0]    sel_a, sel_b;
  logic [NREQ-1:0] gnt_int;
  logic [TMOW-1:0] wd_inc;
  logic            wd_expire;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_a = req_a[i*K +: K];
        sel_b = req_b[i*K +: K];
      end
    end
  end

  // The counter saturates at TMO-1; expiry fires when the next count would reach it.
  assign wd_inc    = (wd_q == TMOW'(TMO - 1)) ? wd_q : wd_q + 1'b1;
  assign wd_expire = (wd_q == TMOW'(TMO - 2));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rsp_d    = rsp_q;
    err_d    = err_q;
    wd_d     = wd_q;
    gnt_int  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_int[win] = 1'b1;
          op1_d    = sel_a;
          op2_d    = sel_b;
          cur_id_d = win;
          rr_ptr_d = IDW'((int'(win) + 1) % NREQ);
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        // A done still high here belongs to an earlier operation and is ignored.
        wd_d = wd_inc;
        if (wd_expire) begin
          rsp_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (!mm_done) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_d = wd_inc;
        if (mm_done) begin
          rsp_d   = mm_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_expire) begin
          rsp_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rsp_q    <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  // Outputs are forced to zero while reset is asserted, including the abort cycle.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    mm_op1    = '0;
    mm_op2    = '0;
    mm_start  = 1'b0;
    busy      = 1'b0;
    cur_id    = '0;
    if (!reset) begin
      gnt      = gnt_int;
      mm_op1   = op1_q;
      mm_op2   = op2_q;
      mm_start = (state_q == ST_LAUNCH);
      busy     = (state_q != ST_IDLE);
      if (state_q != ST_IDLE) cur_id = cur_id_q;
      if (state_q == ST_RESP) begin
        rsp_valid[cur_id_q] = 1'b1;
        rsp_data            = rsp_q;
        rsp_err             = err_q;
      end
    end
  end

  assign dbg_state = state_q;

endmodule
